// File: rtl/pc_gen_if.sv
// rtl/pc_gen_if.sv - redirect, BTB training and fetch-PC bundle for pc_gen
//
// Purpose: groups the execute-stage control inputs and the fetch-side
// outputs of the program-counter generator into a single bus.
// Ports (signals):
//   redirect_valid/redirect_pc           EX redirect request and target
//   upd_valid/upd_pc/upd_target/upd_taken BTB training from resolved branch
//   PC                                   registered fetch PC
//   pred_taken/pred_target               BTB prediction for the current PC
//   redirect_pending                     stalled redirect awaiting en
// Modports: master = EX/fetch consumer side, slave = pc_gen.
interface pc_gen_if #(
  parameter int XLEN = 32
);
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic [XLEN-1:0] upd_target;
  logic            upd_taken;
  logic [XLEN-1:0] PC;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            redirect_pending;

  modport master (
    output redirect_valid, redirect_pc,
    output upd_valid, upd_pc, upd_target, upd_taken,
    input  PC, pred_taken, pred_target, redirect_pending
  );

  modport slave (
    input  redirect_valid, redirect_pc,
    input  upd_valid, upd_pc, upd_target, upd_taken,
    output PC, pred_taken, pred_target, redirect_pending
  );
endinterface

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch PC register with redirect latch and direct-mapped BTB
//
// Purpose: holds the IF-stage fetch PC and selects the next fetch address
// from (highest first) an EX redirect, a redirect latched during a stall,
// a BTB taken prediction, or PC+4.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   en     advance enable; 0 stalls the PC
//   bus    pc_gen_if.slave (redirect, BTB training, PC and prediction outputs)
module pc_gen #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              BTB_ENTRIES  = 16
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     en,
  pc_gen_if.slave  bus
);

  localparam int IDX   = $clog2(BTB_ENTRIES);
  localparam int TAG_W = XLEN - IDX - 2;
  localparam int TGT_W = XLEN - 2;

  // Fetch PC and stalled-redirect latch
  logic [XLEN-1:0] pc_q, pc_d;
  logic            pend_q, pend_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;

  // BTB storage; only the valid bits are reset, the rest are don't-care
  // until an allocation writes them.
  logic [BTB_ENTRIES-1:0] vld_q, vld_d;
  logic [TAG_W-1:0]       tag_q [BTB_ENTRIES];
  logic [TAG_W-1:0]       tag_d [BTB_ENTRIES];
  logic [TGT_W-1:0]       tgt_q [BTB_ENTRIES];
  logic [TGT_W-1:0]       tgt_d [BTB_ENTRIES];
  logic [1:0]             ctr_q [BTB_ENTRIES];
  logic [1:0]             ctr_d [BTB_ENTRIES];

  // Lookup for the current PC
  logic [IDX-1:0]  lk_idx;
  logic            lk_hit;
  logic [XLEN-1:0] pc_plus4;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;

  // Training lookup
  logic [IDX-1:0]  up_idx;
  logic            up_hit;

  logic [XLEN-1:0] nxt_raw;
  logic            unused_lsbs;

  assign lk_idx   = pc_q[IDX+1:2];
  assign pc_plus4 = pc_q + XLEN'(4);   // wraps modulo 2^XLEN
  assign up_idx   = bus.upd_pc[IDX+1:2];

  always_comb begin
    lk_hit      = vld_q[lk_idx] && (tag_q[lk_idx] == pc_q[XLEN-1:IDX+2]);
    pred_taken  = lk_hit && ctr_q[lk_idx][1];
    pred_target = lk_hit ? {tgt_q[lk_idx], 2'b00} : pc_plus4;
  end

  always_comb begin
    up_hit = vld_q[up_idx] && (tag_q[up_idx] == bus.upd_pc[XLEN-1:IDX+2]);
  end

  // Next-PC selection. The pending latch is cleared by any advance, and a
  // redirect seen while stalled overwrites whatever was latched before.
  always_comb begin
    pc_d      = pc_q;
    pend_d    = pend_q;
    pend_pc_d = pend_pc_q;
    nxt_raw   = pc_plus4;
    if (bus.redirect_valid) begin
      nxt_raw = bus.redirect_pc;
    end else if (pend_q) begin
      nxt_raw = pend_pc_q;
    end else if (pred_taken) begin
      nxt_raw = pred_target;
    end
    if (en) begin
      pc_d   = {nxt_raw[XLEN-1:2], 2'b00};
      pend_d = 1'b0;
    end else if (bus.redirect_valid) begin
      pend_d    = 1'b1;
      pend_pc_d = bus.redirect_pc;
    end
  end

  // BTB training, independent of en. Lookup this cycle still sees the
  // pre-update contents because the arrays only change at the edge.
  always_comb begin
    vld_d = vld_q;
    tag_d = tag_q;
    tgt_d = tgt_q;
    ctr_d = ctr_q;
    if (bus.upd_valid) begin
      if (up_hit) begin
        if (bus.upd_taken) begin
          if (ctr_q[up_idx] != 2'b11) begin
            ctr_d[up_idx] = ctr_q[up_idx] + 2'b01;
          end
          tgt_d[up_idx] = bus.upd_target[XLEN-1:2];
        end else if (ctr_q[up_idx] != 2'b00) begin
          ctr_d[up_idx] = ctr_q[up_idx] - 2'b01;
        end
      end else if (bus.upd_taken) begin
        // Allocate weakly-taken, evicting any aliasing occupant
        vld_d[up_idx] = 1'b1;
        tag_d[up_idx] = bus.upd_pc[XLEN-1:IDX+2];
        tgt_d[up_idx] = bus.upd_target[XLEN-1:2];
        ctr_d[up_idx] = 2'b10;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= RESET_VECTOR;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
      vld_q     <= '0;
    end else begin
      pc_q      <= pc_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
      vld_q     <= vld_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q <= tag_d;
    tgt_q <= tgt_d;
    ctr_q <= ctr_d;
  end

  // Byte-offset bits are architecturally ignored on every address input
  assign unused_lsbs = ^{nxt_raw[1:0], bus.upd_pc[1:0], bus.upd_target[1:0]};

  assign bus.PC               = pc_q;
  assign bus.pred_taken       = pred_taken;
  assign bus.pred_target      = pred_target;
  assign bus.redirect_pending = pend_q;

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - scoreboard testbench for pc_gen with a behavioural model
module tb_pc_gen;

  localparam logic [31:0] RV = 32'h0000_0100;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0;

  pc_gen_if #(.XLEN(32)) bus ();

  pc_gen #(.XLEN(32), .RESET_VECTOR(RV), .BTB_ENTRIES(16)) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    bit          ptk;
    logic [31:0] ptg;
    bit          pend;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: fetch state plus a 16-entry table keyed by word index
  logic [31:0] m_pc;
  bit          m_pend;
  logic [31:0] m_ppc;
  bit          m_v   [16];
  logic [31:0] m_tag [16];
  logic [31:0] m_tgt [16];
  int          m_ctr [16];

  function automatic void model_reset();
    m_pc   = RV;
    m_pend = 0;
    m_ppc  = 0;
    for (int i = 0; i < 16; i++) m_v[i] = 0;
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    int i;
    i = (a / 4) % 16;
    return m_v[i] && (m_tag[i] == a / 64);
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    int   i;
    i      = (m_pc / 4) % 16;
    e.pc   = m_pc;
    e.pend = m_pend;
    if (model_hit(m_pc)) begin
      e.ptk = (m_ctr[i] >= 2);
      e.ptg = m_tgt[i] & 32'hFFFF_FFFC;
    end else begin
      e.ptk = 0;
      e.ptg = m_pc + 32'd4;
    end
    return e;
  endfunction

  function automatic void model_step(input bit e, input bit rv, input logic [31:0] rpc,
                                     input bit uv, input logic [31:0] upc,
                                     input logic [31:0] utgt, input bit utk);
    exp_t        o;
    logic [31:0] nxt;
    int          i;
    o = model_out();
    if (e) begin
      if (rv) nxt = rpc;
      else if (m_pend) nxt = m_ppc;
      else if (o.ptk) nxt = o.ptg;
      else nxt = m_pc + 32'd4;
      m_pc   = nxt & 32'hFFFF_FFFC;
      m_pend = 0;
    end else if (rv) begin
      m_pend = 1;
      m_ppc  = rpc;
    end
    if (uv) begin
      i = (upc / 4) % 16;
      if (model_hit(upc)) begin
        if (utk) begin
          m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
          m_tgt[i] = utgt;
        end else begin
          m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
        end
      end else if (utk) begin
        m_v[i]   = 1;
        m_tag[i] = upc / 64;
        m_tgt[i] = utgt;
        m_ctr[i] = 2;
      end
    end
  endfunction

  // One cycle: push expectation for the present state, drive inputs, advance model
  task automatic step(input bit rst, input bit e, input bit rv, input logic [31:0] rpc,
                      input bit uv, input logic [31:0] upc, input logic [31:0] utgt,
                      input bit utk);
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
      exp_q.push_back(model_out());
      reset = 1'b1;
      #1;
      checks++;
      if (bus.PC !== RV) begin
        errors++;
        $display("FAIL async_reset: PC=%h expected %h", bus.PC, RV);
      end
      bus.redirect_valid = 0;
      bus.upd_valid      = 0;
      en                 = 0;
    end else begin
      exp_q.push_back(model_out());
      reset              = 1'b0;
      en                 = e;
      bus.redirect_valid = rv;
      bus.redirect_pc    = rpc;
      bus.upd_valid      = uv;
      bus.upd_pc         = upc;
      bus.upd_target     = utgt;
      bus.upd_taken      = utk;
      model_step(e, rv, rpc, uv, upc, utgt, utk);
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step(0, 1, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic stall(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic redir(input bit e, input logic [31:0] a);
    step(0, e, 1, a, 0, 0, 0, 0);
  endtask
  task automatic train(input logic [31:0] a, input logic [31:0] t, input bit tk);
    step(0, 0, 0, 0, 1, a, t, tk);
  endtask

  // Monitor: compares DUT outputs mid-cycle against the queued expectation
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        checks += 4;
        if (bus.PC !== x.pc) begin
          errors++;
          $display("FAIL pc: got %h expected %h at %0t", bus.PC, x.pc, $time);
        end
        if (bus.pred_taken !== x.ptk) begin
          errors++;
          $display("FAIL pred_taken: got %b expected %b at %0t", bus.pred_taken, x.ptk, $time);
        end
        if (bus.pred_target !== x.ptg) begin
          errors++;
          $display("FAIL pred_target: got %h expected %h at %0t", bus.pred_target, x.ptg, $time);
        end
        if (bus.redirect_pending !== x.pend) begin
          errors++;
          $display("FAIL redirect_pending: got %b expected %b at %0t", bus.redirect_pending, x.pend, $time);
        end
      end
    end
  end

  initial begin
    bus.redirect_valid = 0;
    bus.redirect_pc    = 0;
    bus.upd_valid      = 0;
    bus.upd_pc         = 0;
    bus.upd_target     = 0;
    bus.upd_taken      = 0;
    model_reset();

    // Reset release and sequential fetch, then asynchronous reset mid-run
    step(1, 0, 0, 0, 0, 0, 0, 0);
    run(4);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    run(2);

    // Stall at 0x20 with a redirect captured in stall cycle 2
    redir(1, 32'h20);
    stall(1);
    redir(0, 32'h80);
    stall(1);
    run(2);

    // Newer stalled redirect wins; live redirect beats a pending one
    stall(1);
    redir(0, 32'h80);
    redir(0, 32'hC0);
    run(2);
    redir(0, 32'hC0);
    redir(1, 32'h40);
    run(2);

    // Train 0x10 taken to 0x200, fetch it, then weaken to not-taken
    train(32'h10, 32'h200, 1);
    redir(1, 32'h10);
    run(2);
    train(32'h10, 32'h200, 0);
    train(32'h10, 32'h200, 0);
    redir(1, 32'h10);
    run(2);

    // Aliasing at index 4, and a not-taken miss that must not disturb it
    train(32'h10, 32'h300, 1);
    train(32'h50, 32'h340, 1);
    train(32'h90, 32'h380, 0);
    redir(1, 32'h10);
    run(1);
    redir(1, 32'h50);
    run(2);

    // Wrap-around and low-bit masking on a redirect
    redir(1, 32'hFFFF_FFFC);
    run(2);
    redir(1, 32'h103);
    run(2);

    // Randomised mix within a small address window to provoke hits and aliases
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 6) == 0),
           32'($urandom_range(0, 255)),
           ($urandom_range(0, 2) == 0),
           32'($urandom_range(0, 63)) * 32'd4,
           32'($urandom_range(0, 255)),
           ($urandom_range(0, 2) != 0));
    end
    run(2);

    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the pipelined RISC-V core, successor to the basic stall-only PC register. Holds the fetch PC and selects the next fetch address from four sources. It supports a configurable width and reset vector, execute-stage redirects that are never lost during stalls, and a direct-mapped branch target buffer (BTB) with 2-bit saturating counters for next-PC prediction. Sits at the head of the IF stage, feeding instruction memory and the IF/ID register.

## Interface
- XLEN, 32: PC width in bits (≥ 8).
- RESET_VECTOR, 32'h0000_0000: PC value after reset; bits [1:0] must be 0.
- BTB_ENTRIES, 16: BTB depth; power of 2, ≥ 2. IDX = log2(BTB_ENTRIES).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  PC advance enable; 0 = stall, PC holds.
- redirect_valid  input  1  EX-stage redirect (mispredict, jump, trap).
- redirect_pc  input  XLEN  redirect target.
- upd_valid  input  1  BTB training strobe from EX (resolved branch/jump).
- upd_pc  input  XLEN  PC of the resolved instruction.
- upd_target  input  XLEN  resolved target.
- upd_taken  input  1  resolved direction.
- PC  output  XLEN  current fetch PC (registered).
- pred_taken  output  1  BTB predicts taken for current PC (combinational).
- pred_target  output  XLEN  predicted target for current PC (combinational).
- redirect_pending  output  1  a redirect is latched awaiting en.

## Operation
- BTB entry: valid, tag = PC[XLEN-1:IDX+2], target[XLEN-1:2], ctr[1:0]. Index = PC[IDX+1:2].
- Lookup on current PC: hit = valid && tag match. pred_taken = hit && ctr[1]. pred_target = stored target with bits [1:0] = 0 on hit, else PC+4.
- Next-PC priority when en=1:
  1. redirect_valid → redirect_pc.
  2. pending → pending_pc.
  3. pred_taken → pred_target.
  4. Otherwise PC+4.
- Any load with en=1 clears the pending latch.
- When en=0: PC holds. If redirect_valid, pending is set and pending_pc is written with redirect_pc. A newer redirect overwrites an older pending one.
- Loaded PC has bits [1:0] forced to 0. PC+4 wraps modulo 2^XLEN (for example, all-ones-minus-3 → 0).
- BTB update on upd_valid, independent of en:
  - Hit, taken: ctr saturating increment (max 3); target written.
  - Hit, not taken: ctr saturating decrement (min 0); target unchanged.
  - Miss, taken: allocate. valid=1, tag, target written, ctr=2'b10 (overwrites any occupant).
  - Miss, not taken: no change.
- Reset: PC=RESET_VECTOR, pending=0, all BTB valid=0. Counters and targets are don't-care. Reset mid-stall or mid-pending discards everything.

## Timing
- Redirect latency: 1 cycle. redirect_valid with en=1 at edge N gives PC=redirect_pc after edge N.
- A redirect during a stall appears on PC at the first edge with en=1. redirect_pending=1 from the edge after capture until that edge.
- A BTB update at edge N is visible to lookup from cycle N+1. A lookup in the same cycle as an update to the same index sees the pre-update state.
- pred_taken and pred_target are valid in the same cycle as PC, with no added latency.
- Reset outputs: PC=RESET_VECTOR, pred_taken=0, pred_target=RESET_VECTOR+4, redirect_pending=0.

## Test plan
- Reset with RESET_VECTOR=0x100, en=1, no redirects → PC sequence 0x100, 0x104, 0x108. Assert reset mid-run → PC=0x100 immediately, without waiting for a clock edge.
- en=0 for 3 cycles starting at PC=0x20 → PC stays 0x20. Pulse redirect_valid with redirect_pc=0x80 in stall cycle 2 → redirect_pending=1. First cycle with en=1 → PC=0x80, pending=0.
- en=0, then redirect 0x80 followed by redirect 0xC0 → PC goes to 0xC0 on release. Redirect 0x40 arriving with en=1 in the same cycle as a pending 0xC0 → PC=0x40.
- Train upd_pc=0x10, target=0x200, taken → next fetch of 0x10 gives pred_taken=1 and PC then 0x200. Train 0x10 not-taken twice → ctr 2→1→0, pred_taken=0, fetch of 0x10 is followed by 0x14.
- Alias test with BTB_ENTRIES=16: train 0x10 taken, then 0x50 taken (same index) → lookup of 0x10 misses and 0x50 hits. A not-taken miss leaves the entry unchanged.
- XLEN=32, PC=0xFFFF_FFFC, no hit → next PC=0x0000_0000. redirect_pc=0x103 → PC=0x100.
